// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO behind the UART receiver
//
// Buffers bytes strobed in by the receiver and presents them to the consumer
// through a valid/ready read port. Tracks the fill level and counts writes
// that were dropped because the buffer was full.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   P_DATA       received byte
//   data_valid   write strobe, one write request per high cycle
//   rd_ready     consumer takes the head entry this cycle
//   ovf_clr      clears overflow and drop_count
//   rd_data      head entry, meaningful while rd_valid=1
//   rd_valid     FIFO holds at least one entry
//   empty        fill_count == 0
//   full         fill_count == DEPTH
//   almost_full  fill_count >= AFULL_LEVEL
//   fill_count   number of stored entries, 0..DEPTH
//   overflow     sticky, set when a write is dropped
//   drop_count   saturating count of dropped writes

module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  rd_ready,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam logic [ADDR_WIDTH-1:0] PTR_INC   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_INC   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = AFULL_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic pop;
  logic push;
  logic drop;

  // Status flags come only from the registered fill count, so nothing on the
  // input side reaches an output combinationally.
  assign empty       = (fill_count == '0);
  assign full        = (fill_count == CNT_FULL);
  assign almost_full = (fill_count >= CNT_AFULL);
  assign rd_valid    = ~empty;
  assign rd_data     = mem[rd_ptr];

  // A pop frees the slot the write needs, so a full FIFO still accepts a
  // write in the same cycle as a read.
  assign pop  = rd_valid & rd_ready;
  assign push = data_valid & (~full | pop);
  assign drop = data_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= P_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      case ({push, pop})
        2'b10:   fill_count <= fill_count + CNT_INC;
        2'b01:   fill_count <= fill_count - CNT_INC;
        default: fill_count <= fill_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear counts as the first drop after the
  // clear, so software never loses sight of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int AFL   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          rd_ready;
  logic          ovf_clr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   fill_count;
  logic          overflow;
  logic [7:0]    drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data),
    .data_valid (data_valid),
    .rd_ready   (rd_ready),
    .ovf_clr    (ovf_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .fill_count (fill_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       rr;
    logic       clr;
    int         cnt;
    logic [7:0] data;
    logic       ovf;
    int         drops;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: the stored bytes in arrival order plus the
  // overflow bookkeeping.
  logic [7:0] model_q[$];
  logic       model_ovf;
  int         model_drops;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic dv, input logic [7:0] din, input logic rr,
                     input logic clr, input int cnt, input logic [7:0] data,
                     input logic ovf, input int drops);
    vec_t v;
    v.rst = r; v.dv = dv; v.din = din; v.rr = rr; v.clr = clr;
    v.cnt = cnt; v.data = data; v.ovf = ovf; v.drops = drops;
    vecs.push_back(v);
  endtask

  task automatic tick(input logic r, input logic dv, input logic [7:0] din,
                      input logic rr, input logic clr);
    rst = r; data_valid = dv; p_data = din; rd_ready = rr; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic [7:0] data,
                              input logic ovf, input int drops);
    chk({tag, "_fill"},  32'(fill_count),  32'(cnt));
    chk({tag, "_valid"}, 32'(rd_valid),    32'(cnt > 0));
    chk({tag, "_empty"}, 32'(empty),       32'(cnt == 0));
    chk({tag, "_full"},  32'(full),        32'(cnt == DEPTH));
    chk({tag, "_afull"}, 32'(almost_full), 32'(cnt >= AFL));
    if (cnt > 0) chk({tag, "_data"}, 32'(rd_data), 32'(data));
    chk({tag, "_ovf"},   32'(overflow),    32'(ovf));
    chk({tag, "_drops"}, 32'(drop_count),  32'(drops));
  endtask

  // One cycle of the FIFO rules applied to the queue model.
  task automatic model_step(input logic r, input logic dv, input logic [7:0] din,
                            input logic rr, input logic clr);
    bit do_pop;
    bit do_drop;
    if (r) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_drops = 0;
      return;
    end
    do_pop  = rr && (model_q.size() > 0);
    do_drop = dv && (model_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(model_q.pop_front());
    if (dv && !do_drop) model_q.push_back(din);
    if (do_drop) begin
      model_ovf   = 1'b1;
      model_drops = clr ? 1 : ((model_drops < 255) ? model_drops + 1 : 255);
    end else if (clr) begin
      model_ovf   = 1'b0;
      model_drops = 0;
    end
  endtask

  initial begin
    logic [7:0] tail [9];
    int         pw;
    int         pr;
    logic       r, dv, rr, clr;
    logic [7:0] din;

    rst = 1'b1; data_valid = 1'b0; p_data = '0; rd_ready = 1'b0; ovf_clr = 1'b0;

    // Reset, idle, pop while empty, single write/read.
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

    // Three fill/drain passes carry the pointers through several wraps.
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 8; i++) add(0, 1, 8'(i), 0, 0, i, 8'h01, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 0, 8'h00, 1, 0, 8 - i, 8'(i + 1), 0, 0);
    end

    // Overflow on a full FIFO, then clear.
    for (int i = 1; i <= 8; i++) add(0, 1, 8'(8'h10 + i), 0, 0, i, 8'h11, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 1, 8'hFF, 0, 0, 8, 8'h11, 1, k);
    add(0, 0, 8'h00, 0, 1, 8, 8'h11, 0, 0);

    // Write and read together while full: no drop, 0x55 comes out last.
    add(0, 1, 8'h55, 1, 0, 8, 8'h12, 0, 0);
    tail = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55, 8'h00};
    for (int i = 1; i <= 8; i++) add(0, 0, 8'h00, 1, 0, 8 - i, tail[i], 0, 0);

    // Write and read together while empty: only the write takes effect.
    add(0, 1, 8'h3C, 1, 0, 1, 8'h3C, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

    // Reset with five entries stored, all other inputs active.
    for (int i = 1; i <= 5; i++) add(0, 1, 8'(8'h20 + i), 0, 0, i, 8'h21, 0, 0);
    add(1, 1, 8'h99, 1, 1, 0, 8'h00, 0, 0);
    add(0, 1, 8'h77, 0, 0, 1, 8'h77, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);

    // Drop in the same cycle as a clear counts as one fresh drop.
    for (int i = 1; i <= 8; i++) add(0, 1, 8'(8'h30 + i), 0, 0, i, 8'h31, 0, 0);
    add(0, 1, 8'hEE, 0, 0, 8, 8'h31, 1, 1);
    add(0, 1, 8'hEE, 0, 0, 8, 8'h31, 1, 2);
    add(0, 1, 8'hEE, 0, 1, 8, 8'h31, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].dv, vecs[i].din, vecs[i].rr, vecs[i].clr);
      check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].data, vecs[i].ovf, vecs[i].drops);
    end

    // drop_count saturates at 255 and holds there.
    for (int k = 1; k <= 300; k++) begin
      tick(0, 1, 8'($urandom_range(0, 255)), 0, 0);
      check_status($sformatf("sat%0d", k), 8, 8'h31, 1, (1 + k > 255) ? 255 : 1 + k);
    end
    tick(0, 0, 8'h00, 0, 1);
    check_status("sat_clr", 8, 8'h31, 0, 0);

    // Randomized traffic against the queue model, alternating write-heavy
    // and read-heavy stretches so both full and empty are reached often.
    tick(1, 0, 8'h00, 0, 0);
    model_step(1, 0, 8'h00, 0, 0);
    check_status("rnd_rst", 0, 8'h00, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      pw  = ((c / 100) % 2 == 0) ? 75 : 30;
      pr  = ((c / 100) % 2 == 0) ? 20 : 80;
      r   = ($urandom_range(0, 499) == 0);
      dv  = ($urandom_range(0, 99) < pw);
      rr  = ($urandom_range(0, 99) < pr);
      clr = ($urandom_range(0, 99) < 3);
      din = 8'($urandom_range(0, 255));
      model_step(r, dv, din, rr, clr);
      tick(r, dv, din, rr, clr);
      check_status($sformatf("rnd%0d", c), model_q.size(),
                   (model_q.size() > 0) ? model_q[0] : 8'h00, model_ovf, model_drops);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver top level.
- Captures each received byte when the receiver pulses data_valid with P_DATA.
- Holds bytes in a first-word-fall-through FIFO and presents them to the consumer (CPU/register interface) through a valid/ready read port.
- Reports fill level, almost-full, and a sticky overflow flag with a saturating dropped-byte counter.

Parameters:
- DATA_WIDTH, 8: width of P_DATA and rd_data.
- DEPTH, 8: FIFO entries. Must be a power of 2 and at least 2.
- ADDR_WIDTH, 3: log2(DEPTH). Must be consistent with DEPTH.
- AFULL_LEVEL, 6: almost_full asserts when fill_count >= AFULL_LEVEL. Legal range is 1 to DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  received byte from the UART receiver.
- data_valid  input  1  write strobe; each cycle high is one write request. The receiver drives it as a single-cycle pulse.
- rd_ready  input  1  consumer accepts the head entry this cycle.
- ovf_clr  input  1  clears overflow and drop_count.
- rd_data  output  DATA_WIDTH  head entry; valid only when rd_valid=1.
- rd_valid  output  1  FIFO non-empty (equals ~empty).
- empty  output  1  fill_count==0.
- full  output  1  fill_count==DEPTH.
- almost_full  output  1  fill_count>=AFULL_LEVEL.
- fill_count  output  ADDR_WIDTH+1  number of stored entries, 0 to DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- drop_count  output  8  saturating count of dropped writes, holds at 255.

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and fill_count go to 0.
  - empty=1; full, almost_full, rd_valid and overflow go to 0; drop_count=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all stored bytes. rst has priority over every other input that cycle.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
  - Fullness is tracked by fill_count, not by pointer comparison.
- push_req = data_valid.
- pop = rd_valid & rd_ready. A pop while empty is ignored: no pointer move, no error.
- push accepted = push_req & (~full | pop). Writing while full is allowed when a pop happens in the same cycle.
- On accepted push: mem[wr_ptr] <= P_DATA and wr_ptr increments.
- On pop: rd_ptr increments.
- fill_count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop, or on neither.
- Timing and ordering:
  - First-word fall-through: rd_data = mem[rd_ptr], read combinationally from registered storage.
  - Write-to-read latency is 1 cycle: a byte written at edge N is visible with rd_valid=1 after edge N.
  - Push and pop in the same cycle when empty: rd_valid=0, so no pop; the push is accepted and fill_count becomes 1.
- All status outputs (empty, full, almost_full, rd_valid, fill_count) are registered or derived from registered fill_count. No combinational path from data_valid or rd_ready to any output.
- Overflow:
  - push_req & full & ~pop drops the byte. Storage, pointers and fill_count are unchanged.
  - A drop sets overflow<=1 and drop_count<=min(drop_count+1, 255).
- ovf_clr:
  - Clears overflow and drop_count to 0 at the next edge.
  - If a drop occurs in the same cycle as ovf_clr, the drop wins: overflow=1, drop_count=1.
  - ovf_clr does not affect stored data.
- The FIFO needs no state machine beyond the pointer/counter datapath. Ordering is strictly FIFO with no reordering or duplication.

Test Plan:
- Reset then idle 5 cycles -> empty=1, rd_valid=0, fill_count=0, full=0, overflow=0, drop_count=0.
- Single write P_DATA=0xA5 with data_valid pulse at edge N, rd_ready=0 -> after N: rd_valid=1, rd_data=0xA5, fill_count=1. Then rd_ready=1 for one cycle -> empty=1, fill_count=0.
- Write 0x01..0x08 on 8 consecutive cycles, no reads:
  - fill_count steps 1..8; almost_full=1 from count 6; full=1 at 8.
  - Read all 8 with rd_ready=1 -> rd_data sequence 0x01..0x08, then empty=1.
  - Repeat the fill/drain twice to exercise pointer wrap; data order must be preserved.
- Fill to 8, then write 0xFF three times with rd_ready=0 -> contents unchanged, overflow=1, drop_count=3. Pulse ovf_clr -> overflow=0, drop_count=0, fill_count still 8.
- Full FIFO, data_valid=1 (0x55) and rd_ready=1 in the same cycle -> no drop, overflow=0, fill_count stays 8; the oldest byte is popped; 0x55 is read last after draining.
- Empty FIFO, data_valid=1 (0x3C) with rd_ready=1 -> fill_count=1, rd_data=0x3C next cycle. Separately: assert rst with fill_count=5 -> empty=1, fill_count=0 next cycle; later reads return only newly written bytes.
